// File: rtl/csr_access_ctrl.sv
// CSR access controller: round-robin arbitration between the pipeline and debug
// requesters, then a fixed read / modify / write / acknowledge sequence.
module csr_access_ctrl #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p_req,
  input  logic              d_req,
  input  logic [2:0]        p_op,
  input  logic [2:0]        d_op,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       p_src,
  input  logic [31:0]       d_src,
  output logic              p_ack,
  output logic              d_ack,
  output logic [31:0]       rdata,
  output logic              err,
  output logic              busy,
  output logic              csr_r_en,
  output logic              csr_w_en,
  output logic [ADDR_W-1:0] csr_addr,
  output logic [31:0]       csr_wdata,
  input  logic [31:0]       csr_rdata
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t              state, state_nxt;
  logic                last_dbg_q;
  logic [1:0]          kind_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         operand_q, old_q, wdata_q, rdata_q;
  logic                illegal_q, write_q, err_q;

  logic                any_req, grant_dbg, sel_supp, sel_illegal;
  logic [2:0]          sel_op;
  logic [ADDR_W-1:0]   sel_addr;
  logic [31:0]         sel_src, sel_operand;

  function automatic logic [31:0] operand_of(input logic [2:0] op, input logic [31:0] src);
    logic [31:0] res;
    res = op[2] ? {27'b0, src[4:0]} : src;
    return res;
  endfunction

  function automatic logic [31:0] new_value(input logic [1:0] kind, input logic [31:0] old,
                                            input logic [31:0] opnd);
    logic [31:0] res;
    case (kind)
      2'b01:   res = opnd;
      2'b10:   res = old | opnd;
      default: res = old & ~opnd;
    endcase
    return res;
  endfunction

  // Debug wins only if pipeline is idle or pipeline held the previous grant.
  assign any_req     = p_req | d_req;
  assign grant_dbg   = d_req && (!p_req || !last_dbg_q);
  assign sel_op      = grant_dbg ? d_op   : p_op;
  assign sel_addr    = grant_dbg ? d_addr : p_addr;
  assign sel_src     = grant_dbg ? d_src  : p_src;
  assign sel_operand = operand_of(sel_op, sel_src);
  assign sel_supp    = sel_op[1] && (sel_operand == 32'd0);
  assign sel_illegal = (sel_op[1:0] == 2'b00) ||
                       (!sel_supp && (sel_addr[ADDR_W-1 -: 2] == 2'b11));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = READ;
      READ:    state_nxt = WRITE;
      WRITE:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_dbg_q <= 1'b1;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      illegal_q  <= 1'b0;
      write_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && any_req) begin
        last_dbg_q <= grant_dbg;
        addr_q     <= sel_addr;
        illegal_q  <= sel_illegal;
        write_q    <= !sel_illegal && !sel_supp;
      end
      if (state == READ)
        wdata_q <= new_value(kind_q, csr_rdata, operand_q);
      if (state == WRITE) begin
        rdata_q <= illegal_q ? 32'd0 : old_q;
        err_q   <= illegal_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && any_req) begin
      kind_q    <= sel_op[1:0];
      operand_q <= sel_operand;
    end
    if (state == READ)
      old_q <= csr_rdata;
  end

  // Reset masks every output in the reset cycle itself, including a pending write.
  assign busy      = !rst && (state != IDLE);
  assign csr_r_en  = !rst && (state == READ);
  assign csr_w_en  = !rst && (state == WRITE) && write_q;
  assign p_ack     = !rst && (state == DONE) && !last_dbg_q;
  assign d_ack     = !rst && (state == DONE) && last_dbg_q;
  assign csr_addr  = rst ? '0 : addr_q;
  assign csr_wdata = rst ? 32'd0 : wdata_q;
  assign rdata     = rst ? 32'd0 : rdata_q;
  assign err       = !rst && err_q;

endmodule
